cond_status_unit: RTL and testbench
===================================

Name: cond_status_unit

Overview:
- Multi-lane successor to the single-instruction condition checker.
- Owns the architectural NZCV status register and tracks in-flight flag-setting instructions with a pending counter.
- Evaluates the 4-bit condition field for LANES instruction slots per cycle and stalls issue when the flags are not yet valid.
- Sits between decode/issue and execute; results are registered (1-cycle latency).

Parameters:
- LANES, 2, number of instruction slots evaluated per cycle (1..4).
- PEND_W, 3, width of the pending flag-setter counter; max outstanding = 2^PEND_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; clears pending state and output valids.
- lane_valid  in  LANES  slot i holds an instruction.
- lane_cond  in  4*LANES  condition field of slot i, bits [4i+3:4i].
- lane_sets_flags  in  LANES  slot i will update NZCV later (S bit).
- upd_valid  in  1  execute stage writes flags this cycle.
- upd_flags  in  4  {N,Z,C,V} from execute.
- stall  out  1  issue must hold all lanes this cycle (combinational).
- res_valid  out  LANES  registered: slot i accepted last cycle.
- cond_res  out  LANES  registered: condition outcome of slot i.
- status_regs  out  4  current NZCV register.
- pend_cnt  out  PEND_W  outstanding flag setters.
- err  out  1  sticky: counter overflow or underflow.

Behaviour:
- Reset (async, rst_n=0): status_regs=0, pend_cnt=0, res_valid=0, cond_res=0, err=0.
- Condition encoding:
  - 0 EQ: Z. 1 NE: ~Z. 2 CS: C. 3 CC: ~C. 4 MI: N. 5 PL: ~N. 6 VS: V. 7 VC: ~V.
  - 8 HI: C&~Z. 9 LS: ~C|Z. A GE: N==V. B LT: N!=V.
  - C GT: ~Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F NV: 0.
- Effective flags F_eff: upd_flags if upd_valid, else status_regs (forwarding; see Optional Feature).
- Pending effective P_eff = pend_cnt - (upd_valid && pend_cnt!=0).
- stall = ~flush & (P_eff!=0) & OR over i of (lane_valid[i] & lane_cond[i]!=4'hE). AL-only bundles never stall.
- Accept: lane i is accepted when lane_valid[i] & ~stall & ~flush.
- Next-cycle outputs:
  - res_valid[i] = accepted.
  - cond_res[i] = eval(lane_cond[i], F_eff) & accepted; 0 when not accepted.
- All lanes in one cycle use the same F_eff. A setter in lane j does not affect lanes >j in the same cycle; the compiler/issue logic guarantees no dependent pair shares a bundle.
- status_regs <= upd_flags when upd_valid, regardless of flush or stall.
- pend_cnt next = P_eff + popcount(lane_sets_flags & accepted & cond_pass). A setter whose condition fails never writes flags and is not counted.
- Overflow: if the sum exceeds 2^PEND_W-1, saturate at max and set err.
- Underflow: upd_valid with pend_cnt==0 still updates status_regs, counter stays 0, err set.
- flush: next pend_cnt=0, res_valid=0; status_regs still takes upd_flags; err retained. Flush has priority over acceptance.
- err clears only on reset.

Optional Feature:
- Macro COND_FLAG_FWD_EN.
- Defined: forwarding as above (F_eff may be upd_flags; P_eff subtracts the same-cycle update).
- Undefined:
  - F_eff = status_regs only.
  - P_eff = pend_cnt.
  - The cycle where the last setter retires still stalls; evaluation uses the new status_regs one cycle later (+1 cycle penalty).
  - Saves the bypass mux; functionally identical results.

Test Plan:
- Reset then lane0 valid cond=E, no update -> stall=0; next cycle res_valid=01, cond_res=01, status_regs=0.
- upd_valid=1, upd_flags=0100 (Z) with lane0 cond=0 (EQ), lane1 cond=1 (NE), pend=0 -> next cycle cond_res=01, status_regs=0100.
- lane0 cond=E sets_flags=1 -> pend_cnt=1; next cycle lane0 cond=A -> stall=1, held; then upd_flags=1001 (N,V):
  - FWD_EN: stall=0 that cycle, cond_res=1 next.
  - Without FWD_EN: stall 1 extra cycle, then cond_res=1.
- Setter with failing cond (status Z=0, cond=0, sets_flags=1) -> pend_cnt stays 0.
- Status N=1,V=0,Z=1: cond C -> 0, cond D -> 1, cond F -> 0, cond 9 -> 1.
- PEND_W=2: issue 4 accepted setters -> pend_cnt=3, err=1. upd_valid at pend=0 -> err=1, status updated. Flush with pend=2 -> pend_cnt=0, res_valid=0. rst_n low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/cond_status_unit.sv
// NZCV status register with a pending flag-setter counter and per-lane condition evaluation.
// Define COND_FLAG_FWD_EN to forward same-cycle flag updates to evaluation and stall logic.
module cond_status_unit #(
  parameter int LANES  = 2,
  parameter int PEND_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [LANES-1:0]     lane_valid,
  input  logic [4*LANES-1:0]   lane_cond,
  input  logic [LANES-1:0]     lane_sets_flags,
  input  logic                 upd_valid,
  input  logic [3:0]           upd_flags,
  output logic                 stall,
  output logic [LANES-1:0]     res_valid,
  output logic [LANES-1:0]     cond_res,
  output logic [3:0]           status_regs,
  output logic [PEND_W-1:0]    pend_cnt,
  output logic                 err
);

  localparam int CNT_W = PEND_W + 3;
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'((1 << PEND_W) - 1);

  logic [3:0]        status_q, status_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [LANES-1:0]  res_valid_q, res_valid_d;
  logic [LANES-1:0]  cond_res_q, cond_res_d;
  logic              err_q, err_d;

  logic [3:0]        f_eff;
  logic [PEND_W-1:0] pend_dec, pend_stall;
  logic [CNT_W-1:0]  sets_cnt, sum;
  logic              stall_req, stall_int, acc, pass, dec;

  // f = {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = ~z;
      4'h2:    cond_eval = cy;
      4'h3:    cond_eval = ~cy;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = ~n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = ~v;
      4'h8:    cond_eval = cy & ~z;
      4'h9:    cond_eval = ~cy | z;
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = ~z & (n == v);
      4'hD:    cond_eval = z | (n != v);
      4'hE:    cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  always_comb begin
    stall_req   = 1'b0;
    sets_cnt    = '0;
    res_valid_d = '0;
    cond_res_d  = '0;
    acc         = 1'b0;
    pass        = 1'b0;

    // The counter always retires an update; forwarding only changes what stall/eval see.
    dec      = upd_valid && (pend_q != '0);
    pend_dec = pend_q - PEND_W'(dec);
`ifdef COND_FLAG_FWD_EN
    f_eff      = upd_valid ? upd_flags : status_q;
    pend_stall = pend_dec;
`else
    f_eff      = status_q;
    pend_stall = pend_q;
`endif

    for (int i = 0; i < LANES; i++) begin
      if (lane_valid[i] && (lane_cond[4*i +: 4] != 4'hE)) stall_req = 1'b1;
    end
    stall_int = ~flush & (pend_stall != '0) & stall_req;

    for (int i = 0; i < LANES; i++) begin
      acc            = lane_valid[i] & ~stall_int & ~flush;
      pass           = cond_eval(lane_cond[4*i +: 4], f_eff);
      res_valid_d[i] = acc;
      cond_res_d[i]  = acc & pass;
      sets_cnt       = sets_cnt + CNT_W'(acc & pass & lane_sets_flags[i]);
    end

    sum   = CNT_W'(pend_dec) + sets_cnt;
    err_d = err_q | (upd_valid & (pend_q == '0));
    if (flush) begin
      pend_d = '0;
    end else if (sum > PEND_MAX) begin
      pend_d = '1;
      err_d  = 1'b1;
    end else begin
      pend_d = sum[PEND_W-1:0];
    end

    status_d = upd_valid ? upd_flags : status_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q    <= '0;
      pend_q      <= '0;
      res_valid_q <= '0;
      cond_res_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      status_q    <= status_d;
      pend_q      <= pend_d;
      res_valid_q <= res_valid_d;
      cond_res_q  <= cond_res_d;
      err_q       <= err_d;
    end
  end

  assign stall       = stall_int;
  assign res_valid   = res_valid_q;
  assign cond_res    = cond_res_q;
  assign status_regs = status_q;
  assign pend_cnt    = pend_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cond_status_unit.sv
// Scoreboard bench for cond_status_unit: directed test-plan cases followed by random traffic.
module tb_cond_status_unit;
  localparam int L    = 2;
  localparam int PW   = 3;
  localparam int PMAX = (1 << PW) - 1;
`ifdef COND_FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [L-1:0]  lane_valid = '0, lane_sets_flags = '0;
  logic [4*L-1:0] lane_cond = '0;
  logic          upd_valid = 1'b0;
  logic [3:0]    upd_flags = '0;
  logic          stall, err;
  logic [L-1:0]  res_valid, cond_res;
  logic [3:0]    status_regs;
  logic [PW-1:0] pend_cnt;

  cond_status_unit #(.LANES(L), .PEND_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .lane_valid(lane_valid),
    .lane_cond(lane_cond), .lane_sets_flags(lane_sets_flags),
    .upd_valid(upd_valid), .upd_flags(upd_flags), .stall(stall),
    .res_valid(res_valid), .cond_res(cond_res), .status_regs(status_regs),
    .pend_cnt(pend_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rv;
    int cr;
    int st;
    int pc;
    int er;
  } exp_t;
  exp_t q[$];

  int n_checks = 0, n_fail = 0;
  int m_st = 0, m_pend = 0, m_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_eval(input int c, input int f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1;
      default: return 0;
    endcase
  endfunction

  // Drive one cycle, check stall, and queue the state expected after the next edge.
  task automatic cycle(input int lv, input int c0, input int c1, input int lsf,
                       input int uv, input int uf, input int fl);
    int cond[L];
    int fe, pdec, pst, any_req, exp_stall, cnt, rv, cr, total;
    exp_t e;
    @(negedge clk);
    cond[0] = c0; cond[1] = c1;
    lane_valid      = L'(lv);
    lane_cond       = {4'(c1), 4'(c0)};
    lane_sets_flags = L'(lsf);
    upd_valid       = uv[0];
    upd_flags       = 4'(uf);
    flush           = fl[0];
    #1;
    fe   = (FWD && uv != 0) ? uf : m_st;
    pdec = (uv != 0 && m_pend > 0) ? m_pend - 1 : m_pend;
    pst  = FWD ? pdec : m_pend;
    any_req = 0;
    for (int i = 0; i < L; i++) if (lv[i] && cond[i] != 14) any_req = 1;
    exp_stall = (fl == 0 && pst != 0 && any_req != 0) ? 1 : 0;
    chk("stall", int'(stall), exp_stall);
    cnt = 0; rv = 0; cr = 0;
    for (int i = 0; i < L; i++) begin
      if (lv[i] && !exp_stall && fl == 0) begin
        rv += (1 << i);
        if (ref_eval(cond[i], fe) != 0) begin
          cr += (1 << i);
          if (lsf[i]) cnt++;
        end
      end
    end
    if (uv != 0 && m_pend == 0) m_err = 1;
    if (fl != 0) m_pend = 0;
    else begin
      total = pdec + cnt;
      if (total > PMAX) begin
        m_pend = PMAX;
        m_err  = 1;
      end else m_pend = total;
    end
    if (uv != 0) m_st = uf;
    e.rv = rv; e.cr = cr; e.st = m_st; e.pc = m_pend; e.er = m_err;
    q.push_back(e);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_cond_res"}, int'(cond_res), 0);
    chk({tag, "_status"}, int'(status_regs), 0);
    chk({tag, "_pend"}, int'(pend_cnt), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("res_valid", int'(res_valid), e.rv);
        chk("cond_res", int'(cond_res), e.cr);
        chk("status_regs", int'(status_regs), e.st);
        chk("pend_cnt", int'(pend_cnt), e.pc);
        chk("err", int'(err), e.er);
      end
    end
  end

  initial begin : driver
    #2;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // AL on lane 0, no update
    cycle(1, 14, 0, 0, 0, 0, 0);
    // Z update with EQ / NE
    cycle(3, 0, 1, 0, 1, 4'b0100, 0);
    // AL setter, then GE held until N,V update retires it
    cycle(1, 14, 0, 1, 0, 0, 0);
    cycle(1, 10, 0, 0, 0, 0, 0);
    cycle(1, 10, 0, 0, 1, 4'b1001, 0);
    cycle(1, 10, 0, 0, 0, 0, 0);
    cycle(1, 10, 0, 0, 0, 0, 0);
    // failing setter is not counted (Z=0, EQ)
    cycle(1, 0, 0, 1, 0, 0, 0);
    // underflow update sets N,Z (V=0), then GT/LE/LS/NV
    cycle(0, 0, 0, 0, 1, 4'b1100, 0);
    cycle(3, 12, 13, 0, 0, 0, 0);
    cycle(3, 9, 15, 0, 0, 0, 0);
    // overflow: 8 AL setters into a 7-deep counter
    repeat (4) cycle(3, 14, 14, 3, 0, 0, 0);
    // flush with pending setters and valid lanes
    cycle(3, 14, 14, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // async reset while stalled
    cycle(3, 14, 14, 3, 0, 0, 0);
    cycle(1, 4, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    q.delete();
    m_st = 0; m_pend = 0; m_err = 0;
    lane_valid = '0; upd_valid = 1'b0; flush = 1'b0; lane_sets_flags = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 400; k++) begin
      int c0, c1, lsf, uv, fl;
      c0  = ($urandom_range(0, 3) == 0) ? 14 : int'($urandom_range(0, 15));
      c1  = ($urandom_range(0, 3) == 0) ? 14 : int'($urandom_range(0, 15));
      lsf = {int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3) == 0)};
      lsf = ((lsf >> 1) << 1) | (lsf & 1);
      uv  = ($urandom_range(0, 9) < 4) ? 1 : 0;
      fl  = ($urandom_range(0, 19) == 0) ? 1 : 0;
      cycle(int'($urandom_range(0, 3)), c0, c1, lsf, uv, int'($urandom_range(0, 15)), fl);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
